// File: rtl/seq_divider_16bit_pkg.sv
// Shared types and constants for the sequential divider.
// FSM encoding plus special-case result values.
package seq_divider_16bit_pkg;

  localparam int DIV_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DIVIDE = 2'b01,
    FIXUP  = 2'b10
  } div_state_e;

  localparam logic [DIV_W-1:0] DIV_ZERO_Q = '1;
  localparam logic [DIV_W-1:0] SAT_POS    = 16'h7FFF;

endpackage

// File: rtl/seq_divider_16bit_if.sv
// Request/result bundle between the pipeline and the divider.
// master drives the request, slave returns results.
interface seq_divider_16bit_if #(
  parameter int WIDTH = 16
) ();

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             ovfl;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder,
    input  div_by_zero, ovfl
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder,
    output div_by_zero, ovfl
  );

endinterface

// File: rtl/seq_divider_16bit_div_step.sv
// One restoring-division iteration: shift in the next
// dividend bit, trial-subtract, keep or restore.
module seq_divider_16bit_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           ge;

  // Partial remainder needs WIDTH+1 bits before the subtract.
  assign shifted = {rem_i, q_i[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_i};
  assign ge      = (shifted >= {1'b0, dvs_i});
  assign rem_o   = WIDTH'(ge ? trial : shifted);
  assign q_o     = {q_i[WIDTH-2:0], ge};

endmodule

// File: rtl/seq_divider_16bit.sv
// Multi-cycle signed/unsigned restoring divider.
// One quotient bit per cycle; results hold until next op.
module seq_divider_16bit
  import seq_divider_16bit_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input logic              clk,
  input logic              rst,
  seq_divider_16bit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MINV =
    {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, q_q, dvs_q;
  logic             qneg_q, rneg_q;
  logic             dz_q, ov_q;
  logic             done_q, dzo_q, ovo_q;
  logic [WIDTH-1:0] quo_q, rmd_q;

  logic             a_neg, b_neg;
  logic [WIDTH:0]   a_ext, b_ext;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             dz_c, ov_c;
  logic [WIDTH-1:0] rem_d, q_d;

  // Magnitudes in WIDTH+1 bits so MIN maps to 2^(WIDTH-1).
  assign a_neg = bus.is_signed & bus.dividend[WIDTH-1];
  assign b_neg = bus.is_signed & bus.divisor[WIDTH-1];
  assign a_ext = {a_neg, bus.dividend};
  assign b_ext = {b_neg, bus.divisor};
  assign a_mag = WIDTH'(a_neg ? -a_ext : a_ext);
  assign b_mag = WIDTH'(b_neg ? -b_ext : b_ext);
  assign dz_c  = (bus.divisor == '0);
  assign ov_c  = bus.is_signed & (bus.dividend == MINV)
               & (bus.divisor == '1);

  seq_divider_16bit_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .q_i   (q_q),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .q_o   (q_d)
  );

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;
  assign bus.div_by_zero = dzo_q;
  assign bus.ovfl        = ovo_q;

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
      dzo_q   <= 1'b0;
      ovo_q   <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            dzo_q   <= 1'b0;
            ovo_q   <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= b_mag;
            qneg_q  <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            dz_q    <= dz_c;
            ov_q    <= ov_c;
            // Special cases keep the raw dividend for the remainder.
            q_q     <= (dz_c | ov_c) ? bus.dividend : a_mag;
            state_q <= (dz_c | ov_c) ? FIXUP : DIVIDE;
          end
        end
        DIVIDE: begin
          rem_q <= rem_d;
          q_q   <= q_d;
          if (cnt_q == CW'(WIDTH-1)) begin
            state_q <= FIXUP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIXUP: begin
          // Special cases spend one settle cycle here.
          if ((dz_q | ov_q) && (cnt_q == '0)) begin
            cnt_q <= CW'(1);
          end else begin
            if (dz_q) begin
              quo_q <= WIDTH'(DIV_ZERO_Q);
              rmd_q <= q_q;
              dzo_q <= 1'b1;
            end else if (ov_q) begin
              quo_q <= WIDTH'(SAT_POS);
              rmd_q <= '0;
              ovo_q <= 1'b1;
            end else begin
              quo_q <= qneg_q ? -q_q : q_q;
              rmd_q <= rneg_q ? -rem_q : rem_q;
            end
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
